latch_write_sequencer: RTL and testbench

//   Synchronous front end for a bank of transparent D latches (D/G inputs). Accepts write

---
 rtl/latch_write_sequencer.sv | 101 ++++++++++
 tb/tb_latch_write_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: drives a transparent-latch bank with a setup -> gate -> hold
// write sequence so the shared D bus is stable whenever any gate is open.
module latch_write_sequencer #(
    parameter int DATA_W    = 8,
    parameter int NUM_LATCH = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic [DATA_W-1:0]    lat_d,
    output logic [NUM_LATCH-1:0] lat_g,
    output logic                 busy,
    output logic                 wr_done,
    output logic                 addr_err
);
    typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;
    localparam logic [ADDR_W:0] NL = (ADDR_W+1)'(NUM_LATCH);
    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    // The counter holds remaining cycles minus one, so a state exits when it reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            lat_d     <= '0;
            lat_g     <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            wr_done   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            wr_done  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        if ({1'b0, req_addr} >= NL) begin
                            addr_err <= 1'b1;
                        end else begin
                            addr_q    <= req_addr;
                            lat_d     <= req_data;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            if (SETUP_CYC > 0) begin
                                state <= SETUP;
                                cnt   <= 4'(SETUP_CYC - 1);
                            end else begin
                                state <= GATE;
                                cnt   <= 4'(PULSE_CYC - 1);
                                lat_g <= NUM_LATCH'(1) << req_addr;
                            end
                        end
                    end
                end
                SETUP: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        state <= GATE;
                        cnt   <= 4'(PULSE_CYC - 1);
                        lat_g <= NUM_LATCH'(1) << addr_q;
                    end
                end
                GATE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        lat_g <= '0;
                        if (HOLD_CYC > 0) begin
                            state <= HOLD;
                            cnt   <= 4'(HOLD_CYC - 1);
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            wr_done   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        wr_done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: vector table, directed corner sequences and a random run
// checked against a timeline model, on a default instance and a 3-latch zero-setup/hold one.
module tb_latch_write_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [1:0] a0 = '0, a1 = '0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       r0, r1, b0, b1, w0, w1, e0, e1;
    logic [7:0] ld0, ld1;
    logic [3:0] g0;
    logic [2:0] g1;
    latch_write_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0), .req_addr(a0),
        .req_data(d0), .lat_d(ld0), .lat_g(g0), .busy(b0), .wr_done(w0), .addr_err(e0)
    );
    latch_write_sequencer #(.NUM_LATCH(3), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1), .req_addr(a1),
        .req_data(d1), .lat_d(ld1), .lat_g(g1), .busy(b1), .wr_done(w1), .addr_err(e1)
    );
    logic [3:0] og[2];
    logic [7:0] od[2];
    logic       or_[2], ob[2], ow[2], oe[2];
    assign og[0] = g0;  assign og[1] = {1'b0, g1};
    assign od[0] = ld0; assign od[1] = ld1;
    assign or_[0] = r0; assign or_[1] = r1;
    assign ob[0] = b0;  assign ob[1] = b1;
    assign ow[0] = w0;  assign ow[1] = w1;
    assign oe[0] = e0;  assign oe[1] = e1;

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit sel; bit v; logic [1:0] a; logic [7:0] d;
        logic [3:0] g; logic [7:0] ld; bit rdy; bit bsy; bit done; bit err;
    } vec_t;
    vec_t tv[14];

    int S[2] = '{1, 0};
    int P[2] = '{2, 1};
    int H[2] = '{1, 0};
    int NL[2] = '{4, 3};
    int acc[2], errc[2], ma[2];
    logic [7:0] md[2];
    int cyc, rel, L;
    bit mbsy;
    logic [3:0] eg;
    logic [3:0] exp_g[10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};

    initial begin
        tv = '{
            '{0, 1, 2'd2, 8'hA5, 4'h0, 8'h00, 1, 0, 0, 0},
            '{0, 0, 2'd0, 8'h00, 4'h0, 8'hA5, 0, 1, 0, 0},
            '{0, 0, 2'd0, 8'h00, 4'h4, 8'hA5, 0, 1, 0, 0},
            '{0, 0, 2'd0, 8'h00, 4'h4, 8'hA5, 0, 1, 0, 0},
            '{0, 0, 2'd0, 8'h00, 4'h0, 8'hA5, 0, 1, 0, 0},
            '{0, 0, 2'd0, 8'h00, 4'h0, 8'hA5, 1, 0, 1, 0},
            '{0, 0, 2'd0, 8'h00, 4'h0, 8'hA5, 1, 0, 0, 0},
            '{1, 1, 2'd3, 8'h77, 4'h0, 8'h00, 1, 0, 0, 0},
            '{1, 0, 2'd0, 8'h00, 4'h0, 8'h00, 1, 0, 0, 1},
            '{1, 0, 2'd0, 8'h00, 4'h0, 8'h00, 1, 0, 0, 0},
            '{1, 1, 2'd1, 8'h3C, 4'h0, 8'h00, 1, 0, 0, 0},
            '{1, 0, 2'd0, 8'h00, 4'h2, 8'h3C, 0, 1, 0, 0},
            '{1, 0, 2'd0, 8'h00, 4'h0, 8'h3C, 1, 0, 1, 0},
            '{1, 0, 2'd0, 8'h00, 4'h0, 8'h3C, 1, 0, 0, 0}
        };
        // power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("por_ready", r0, 0); chk("por_g", g0, 0); chk("por_busy", b0, 0); chk("por_d", ld0, 0);
        rst_n = 1'b1;
        step();
        chk("por_ready_after", r0, 1); chk("por_ready_after_u1", r1, 1);

        // vector table: single write on u0, bad address and zero setup/hold on u1
        for (int i = 0; i < 14; i++) begin
            v0 = tv[i].v & !tv[i].sel; a0 = tv[i].a; d0 = tv[i].d;
            v1 = tv[i].v & tv[i].sel;  a1 = tv[i].a; d1 = tv[i].d;
            chk($sformatf("tv%0d_g", i), og[tv[i].sel], tv[i].g);
            chk($sformatf("tv%0d_d", i), od[tv[i].sel], tv[i].ld);
            chk($sformatf("tv%0d_rdy", i), or_[tv[i].sel], tv[i].rdy);
            chk($sformatf("tv%0d_busy", i), ob[tv[i].sel], tv[i].bsy);
            chk($sformatf("tv%0d_done", i), ow[tv[i].sel], tv[i].done);
            chk($sformatf("tv%0d_err", i), oe[tv[i].sel], tv[i].err);
            step();
        end
        v0 = 0; v1 = 0;

        // reset in the middle of the gate pulse
        v0 = 1; a0 = 2'd1; d0 = 8'h42;
        step();
        v0 = 0;
        step();
        chk("midrst_pre_g", g0, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_g", g0, 0); chk("midrst_ready", r0, 0); chk("midrst_d", ld0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("midrst_ready_after", r0, 1); chk("midrst_d_after", ld0, 0); chk("midrst_busy", b0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_done", w0, 0); chk("midrst_g_idle", g0, 0);
            step();
        end

        // back-to-back writes with valid held high
        v0 = 1; a0 = 2'd0; d0 = 8'h11;
        step();
        a0 = 2'd3; d0 = 8'hEE;
        for (int c = 1; c <= 10; c++) begin
            if (c >= 6) v0 = 0;
            chk($sformatf("b2b_g%0d", c), g0, exp_g[c-1]);
            chk($sformatf("b2b_d%0d", c), ld0, c <= 5 ? 8'h11 : 8'hEE);
            chk($sformatf("b2b_rdy%0d", c), r0, (c == 5 || c == 10) ? 1 : 0);
            step();
        end

        // request while busy is ignored
        v0 = 1; a0 = 2'd2; d0 = 8'h5A;
        step();
        v0 = 0;
        step();
        chk("busy_ready", r0, 0);
        v0 = 1; a0 = 2'd0; d0 = 8'hFF;
        step();
        v0 = 0;
        chk("busy_g", g0, 4'b0100); chk("busy_d", ld0, 8'h5A);
        step();
        chk("busy_hold_g", g0, 0);
        step();
        chk("busy_done", w0, 1); chk("busy_done_d", ld0, 8'h5A);
        step();
        chk("busy_idle", b0, 0); chk("busy_idle_g", g0, 0); chk("busy_idle_d", ld0, 8'h5A);

        // random traffic against the timeline model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            acc[i] = -100; errc[i] = -100; ma[i] = 0; md[i] = 8'h00;
        end
        for (int n = 0; n < 400; n++) begin
            v0 = ($urandom_range(0, 1) == 1); a0 = 2'($urandom_range(0, 3)); d0 = 8'($urandom);
            v1 = ($urandom_range(0, 1) == 1); a1 = 2'($urandom_range(0, 3)); d1 = 8'($urandom);
            for (int i = 0; i < 2; i++) begin
                rel = cyc - acc[i];
                L = S[i] + P[i] + H[i];
                mbsy = rel >= 0 && rel < L;
                eg = (rel >= S[i] && rel < S[i] + P[i]) ? 4'(1 << ma[i]) : 4'h0;
                chk($sformatf("rnd%0d_g", i), og[i], eg);
                chk($sformatf("rnd%0d_d", i), od[i], md[i]);
                chk($sformatf("rnd%0d_rdy", i), or_[i], !mbsy);
                chk($sformatf("rnd%0d_busy", i), ob[i], mbsy);
                chk($sformatf("rnd%0d_done", i), ow[i], rel == L);
                chk($sformatf("rnd%0d_err", i), oe[i], cyc == errc[i]);
                chk($sformatf("rnd%0d_onehot", i), $onehot0(og[i]), 1);
                if ((i == 0 ? v0 : v1) && !mbsy) begin
                    if (int'(i == 0 ? a0 : a1) >= NL[i]) errc[i] = cyc + 1;
                    else begin
                        acc[i] = cyc + 1;
                        ma[i] = int'(i == 0 ? a0 : a1);
                        md[i] = i == 0 ? d0 : d1;
                    end
                end
            end
            step();
            cyc++;
        end
        v0 = 0; v1 = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
